// File: rtl/vector_mem_pkg.sv
// Shared types and defaults for the vector MEM-stage responder.
// Optional feature macro: VMEM_RANGE_CHECK_EN (used by vector_mem_responder).
package vector_mem_pkg;

   // Default geometry: 6 lanes of 8 bits, 32-bit request address, 1 KiB byte RAM.
   localparam int unsigned DEF_R  = 6;
   localparam int unsigned DEF_N  = 8;
   localparam int unsigned DEF_I  = 32;
   localparam int unsigned DEF_AW = 10;

   // Sequencer states.
   typedef enum logic [2:0] {
      StIdle,
      StWr,
      StRd,
      StRdLast,
      StResp
   } vmem_state_t;

   // Lane vector at the default geometry.
   typedef logic [DEF_R-1:0][DEF_N-1:0] lane_vec_t;

   // Width of a lane index; at least one bit even for a single lane.
   function automatic int unsigned lane_idx_w(input int unsigned r);
      return (r > 1) ? $clog2(r) : 1;
   endfunction

endpackage

// File: rtl/vmem_lane_pack.sv
// Load-lane assembly: a shadow register collects one byte per cycle, and the
// completed vector is published to the visible read-data register in one step.
module vmem_lane_pack
   import vector_mem_pkg::*;
#(
   parameter int unsigned R  = DEF_R,
   parameter int unsigned N  = DEF_N,
   parameter int unsigned KW = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cap_en,
   input  logic [KW-1:0]         cap_idx,
   input  logic [N-1:0]          cap_data,
   input  logic                  publish,
   output logic [R-1:0][N-1:0]   read_data
);

   logic [R-1:0][N-1:0] shadow_q;
   logic [R-1:0][N-1:0] merged;
   logic [R-1:0][N-1:0] read_data_q;

   // Shadow contents including this cycle's capture, so publish can carry the final lane.
   always_comb begin
      merged = shadow_q;
      if (cap_en) begin
         merged[cap_idx] = cap_data;
      end
   end

   // Shadow tracks captures; the visible vector changes only on publish.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         shadow_q    <= '0;
         read_data_q <= '0;
      end else begin
         shadow_q <= merged;
         if (publish) begin
            read_data_q <= merged;
         end
      end
   end

   assign read_data = read_data_q;

endmodule

// File: rtl/vector_mem_responder.sv
// Vector MEM-stage responder: serialises one R-lane load/store into R byte
// accesses on a synchronous single-port RAM and returns the assembled vector.
// Optional feature macro: VMEM_RANGE_CHECK_EN (reject requests whose byte span
// leaves the RAM instead of wrapping; reported with an Err pulse).
module vector_mem_responder
   import vector_mem_pkg::*;
#(
   parameter int unsigned R  = DEF_R,
   parameter int unsigned N  = DEF_N,
   parameter int unsigned I  = DEF_I,
   parameter int unsigned AW = DEF_AW
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 MemReq,
   input  logic                 MemWrite,
   input  logic [I-1:0]         Address,
   input  logic [R-1:0][N-1:0]  WriteData,
   output logic                 Ready,
   output logic                 RespValid,
   output logic                 Err,
   output logic [R-1:0][N-1:0]  ReadData,
   output logic [AW-1:0]        ram_addr,
   output logic                 ram_we,
   output logic [N-1:0]         ram_wdata,
   input  logic [N-1:0]         ram_rdata
);

   localparam int unsigned   KW     = lane_idx_w(R);
   localparam logic [KW-1:0] K_LAST = KW'(R - 1);

   vmem_state_t         state_q;
   logic [KW-1:0]       k_q;
   logic [AW-1:0]       base_q;
   logic [R-1:0][N-1:0] wvec_q;
   logic                ready_q;
   logic                resp_valid_q;
   logic                err_q;
   logic [AW-1:0]       ram_addr_q;
   logic                ram_we_q;
   logic [N-1:0]        ram_wdata_q;

   logic [KW-1:0]       k_next;
   logic [AW-1:0]       addr_next;
   logic                range_bad;
   logic                cap_en;
   logic [KW-1:0]       cap_idx;
   logic                publish;

   // Next lane index and its byte address; the sum wraps modulo 2^AW.
   assign k_next    = k_q + KW'(1);
   assign addr_next = base_q + AW'(k_next);

`ifdef VMEM_RANGE_CHECK_EN
   logic [AW:0] last_byte;

   // Reject when upper address bits are set or the last lane runs past the top byte.
   assign last_byte = {1'b0, Address[AW-1:0]} + (AW+1)'(R - 1);
   assign range_bad = (Address[I-1:AW] != '0) || last_byte[AW];
`else
   // Upper address bits are ignored; the span simply wraps.
   logic unused_addr_hi;
   assign unused_addr_hi = ^Address[I-1:AW];
   assign range_bad      = 1'b0;
`endif

   // Sequencer, lane counter and all registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= StIdle;
         k_q          <= '0;
         base_q       <= '0;
         wvec_q       <= '0;
         ready_q      <= 1'b1;
         resp_valid_q <= 1'b0;
         err_q        <= 1'b0;
         ram_addr_q   <= '0;
         ram_we_q     <= 1'b0;
         ram_wdata_q  <= '0;
      end else begin
         resp_valid_q <= 1'b0;
         err_q        <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (MemReq) begin
                  ready_q <= 1'b0;
                  base_q  <= Address[AW-1:0];
                  wvec_q  <= WriteData;
                  k_q     <= '0;
                  if (range_bad) begin
                     // No RAM traffic; report error and completion together.
                     state_q      <= StResp;
                     resp_valid_q <= 1'b1;
                     err_q        <= 1'b1;
                  end else begin
                     // First access is presented in the cycle right after accept.
                     ram_addr_q <= Address[AW-1:0];
                     ram_we_q   <= MemWrite;
                     if (MemWrite) begin
                        ram_wdata_q <= WriteData[0];
                        state_q     <= StWr;
                     end else begin
                        state_q <= StRd;
                     end
                  end
               end
            end
            StWr: begin
               if (k_q == K_LAST) begin
                  ram_we_q     <= 1'b0;
                  resp_valid_q <= 1'b1;
                  state_q      <= StResp;
               end else begin
                  k_q         <= k_next;
                  ram_addr_q  <= addr_next;
                  ram_wdata_q <= wvec_q[k_next];
               end
            end
            StRd: begin
               if (k_q == K_LAST) begin
                  state_q <= StRdLast;
               end else begin
                  k_q        <= k_next;
                  ram_addr_q <= addr_next;
               end
            end
            StRdLast: begin
               // Final byte is captured and published on this edge.
               resp_valid_q <= 1'b1;
               state_q      <= StResp;
            end
            StResp: begin
               ready_q <= 1'b1;
               state_q <= StIdle;
            end
            default: begin
               ready_q <= 1'b1;
               state_q <= StIdle;
            end
         endcase
      end
   end

   // Read data lags the address by one cycle, so lane k-1 lands while address k is out.
   always_comb begin
      cap_en  = 1'b0;
      cap_idx = k_q - KW'(1);
      publish = 1'b0;
      if (state_q == StRd) begin
         cap_en = (k_q != '0);
      end else if (state_q == StRdLast) begin
         cap_en  = 1'b1;
         cap_idx = K_LAST;
         publish = 1'b1;
      end
   end

   vmem_lane_pack #(
      .R  (R),
      .N  (N),
      .KW (KW)
   ) u_lane_pack (
      .clk       (clk),
      .reset     (reset),
      .cap_en    (cap_en),
      .cap_idx   (cap_idx),
      .cap_data  (ram_rdata),
      .publish   (publish),
      .read_data (ReadData)
   );

   assign Ready     = ready_q;
   assign RespValid = resp_valid_q;
   assign Err       = err_q;
   assign ram_addr  = ram_addr_q;
   assign ram_we    = ram_we_q;
   assign ram_wdata = ram_wdata_q;

endmodule

// File: tb/tb_vector_mem_responder.sv
// Self-checking bench for vector_mem_responder: directed cases plus random
// load/store traffic against a byte-array reference model.
module tb_vector_mem_responder;
   import vector_mem_pkg::*;

   localparam int unsigned R     = DEF_R;
   localparam int unsigned N     = DEF_N;
   localparam int unsigned I     = DEF_I;
   localparam int unsigned AW    = DEF_AW;
   localparam int unsigned DEPTH = 1 << AW;

   logic          clk       = 1'b0;
   logic          reset     = 1'b0;
   logic          MemReq    = 1'b0;
   logic          MemWrite  = 1'b0;
   logic [I-1:0]  Address   = '0;
   lane_vec_t     WriteData = '0;
   logic          Ready;
   logic          RespValid;
   logic          Err;
   lane_vec_t     ReadData;
   logic [AW-1:0] ram_addr;
   logic          ram_we;
   logic [N-1:0]  ram_wdata;
   logic [N-1:0]  ram_rdata;

   // External RAM and its write counter.
   logic [N-1:0]  ram [DEPTH];
   logic          ram_init_done = 1'b0;
   int            n_writes = 0;

   // Reference model state.
   logic [N-1:0]  ref_mem [DEPTH];
   lane_vec_t     ref_rd;

   int            n_vec     = 0;
   int            n_miscmp  = 0;

   always #5 clk = ~clk;

   vector_mem_responder #(
      .R  (R),
      .N  (N),
      .I  (I),
      .AW (AW)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .MemReq    (MemReq),
      .MemWrite  (MemWrite),
      .Address   (Address),
      .WriteData (WriteData),
      .Ready     (Ready),
      .RespValid (RespValid),
      .Err       (Err),
      .ReadData  (ReadData),
      .ram_addr  (ram_addr),
      .ram_we    (ram_we),
      .ram_wdata (ram_wdata),
      .ram_rdata (ram_rdata)
   );

   function automatic logic [N-1:0] init_byte(input int idx);
      return N'(idx * 37 + 11);
   endfunction

   // Synchronous single-port byte RAM; contents seeded on the first edge.
   always @(posedge clk) begin
      if (!ram_init_done) begin
         for (int i = 0; i < int'(DEPTH); i++) ram[i] <= init_byte(i);
         ram_init_done <= 1'b1;
      end else begin
         if (ram_we) begin
            ram[ram_addr] <= ram_wdata;
            n_writes      <= n_writes + 1;
         end
         ram_rdata <= ram[ram_addr];
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miscmp++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic lane_vec_t rand_vec();
      lane_vec_t v;
      for (int i = 0; i < int'(R); i++) v[i] = N'($urandom);
      return v;
   endfunction

   function automatic logic range_violation(input logic [I-1:0] a);
`ifdef VMEM_RANGE_CHECK_EN
      return ((a >> AW) != 0) || ((int'(a[AW-1:0]) + int'(R) - 1) >= int'(DEPTH));
`else
      return (a == '1) && (a != '1);
`endif
   endfunction

   function automatic int wrap_idx(input logic [I-1:0] a, input int i);
      return (int'(a[AW-1:0]) + i) % int'(DEPTH);
   endfunction

   // One complete request, with latency, data, handshake and RAM-content checks.
   task automatic do_txn(input logic wr, input logic [I-1:0] a, input lane_vec_t wd);
      int   lat;
      int   w0;
      int   exp_lat;
      logic bad;
      bad = range_violation(a);
      @(negedge clk);
      check("ready_idle", Ready, 1'b1);
      MemReq    = 1'b1;
      MemWrite  = wr;
      Address   = a;
      WriteData = wd;
      w0        = n_writes;
      @(posedge clk);
      #1;
      MemReq    = 1'b0;
      MemWrite  = 1'($urandom);
      Address   = $urandom;
      WriteData = rand_vec();
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!RespValid && lat < 40);
      if (bad) exp_lat = 1;
      else if (wr) exp_lat = int'(R) + 1;
      else exp_lat = int'(R) + 2;
      if (!bad) begin
         for (int i = 0; i < int'(R); i++) begin
            if (wr) ref_mem[wrap_idx(a, i)] = wd[i];
            else ref_rd[i] = ref_mem[wrap_idx(a, i)];
         end
      end
      check("resp_latency", lat, exp_lat);
      check("err_pulse", Err, bad);
      check("read_data", ReadData, ref_rd);
      check("busy_ready", Ready, 1'b0);
      @(negedge clk);
      check("resp_one_cycle", RespValid, 1'b0);
      check("ready_back", Ready, 1'b1);
      check("write_count", n_writes - w0, (wr && !bad) ? int'(R) : 0);
      for (int i = 0; i < int'(R); i++) begin
         check("ram_byte", ram[wrap_idx(a, i)], ref_mem[wrap_idx(a, i)]);
      end
   endtask

   // Requester holds MemReq high throughout; the second accept lands at cycle R+3.
   task automatic busy_test(input logic [I-1:0] a);
      int n_resp;
      int resp_at;
      int ready_at;
      int lat;
      int w0;
      n_resp   = 0;
      resp_at  = -1;
      ready_at = -1;
      w0       = n_writes;
      @(negedge clk);
      MemReq   = 1'b1;
      MemWrite = 1'b0;
      Address  = a;
      for (int c = 1; c <= int'(R) + 3; c++) begin
         @(negedge clk);
         if (RespValid) begin
            n_resp++;
            resp_at = c;
         end
         if (Ready && ready_at < 0) ready_at = c;
      end
      for (int i = 0; i < int'(R); i++) ref_rd[i] = ref_mem[wrap_idx(a, i)];
      check("busy_resp_count", n_resp, 1);
      check("busy_resp_cycle", resp_at, int'(R) + 2);
      check("busy_ready_cycle", ready_at, int'(R) + 3);
      check("busy_read_data", ReadData, ref_rd);
      @(posedge clk);
      #1;
      MemReq = 1'b0;
      @(negedge clk);
      check("second_accepted", Ready, 1'b0);
      lat = 1;
      while (!RespValid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      check("second_latency", lat, int'(R) + 2);
      check("second_read_data", ReadData, ref_rd);
      check("busy_no_writes", n_writes - w0, 0);
      @(negedge clk);
   endtask

   // Asynchronous reset after the third store write.
   task automatic reset_mid_store(input lane_vec_t wd);
      @(negedge clk);
      MemReq    = 1'b1;
      MemWrite  = 1'b1;
      Address   = '0;
      WriteData = wd;
      @(posedge clk);
      #1;
      MemReq = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      check("rst_ready", Ready, 1'b1);
      check("rst_resp", RespValid, 1'b0);
      check("rst_err", Err, 1'b0);
      check("rst_ram_we", ram_we, 1'b0);
      check("rst_ram_addr", ram_addr, '0);
      check("rst_ram_wdata", ram_wdata, '0);
      check("rst_read_data", ReadData, '0);
      for (int i = 0; i < 3; i++) ref_mem[i] = wd[i];
      ref_rd = '0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("rst_ready_after", Ready, 1'b1);
      for (int i = 0; i < int'(R); i++) check("rst_ram_byte", ram[i], ref_mem[i]);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      lane_vec_t v;
      logic [I-1:0] a;
      for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = init_byte(i);
      ref_rd = '0;

      reset = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_ready", Ready, 1'b1);
      check("reset_resp", RespValid, 1'b0);
      check("reset_err", Err, 1'b0);
      check("reset_read_data", ReadData, '0);
      check("reset_ram_addr", ram_addr, '0);
      check("reset_ram_we", ram_we, 1'b0);
      check("reset_ram_wdata", ram_wdata, '0);
      reset = 1'b1;

      v = {8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
      do_txn(1'b1, 32'h10, v);
      do_txn(1'b0, 32'h10, rand_vec());
      check("store_load_vector", ReadData, v);

      // Span crossing the top of the RAM; a second store with upper bits set.
      do_txn(1'b1, 32'h3FE, rand_vec());
      do_txn(1'b0, 32'h3FE, rand_vec());
      do_txn(1'b1, 32'h400, rand_vec());
      do_txn(1'b0, 32'h0, rand_vec());

      busy_test(32'h20);

      for (int t = 0; t < 60; t++) begin
         case ($urandom_range(0, 7))
            0:       a = 32'(DEPTH - 1 - $urandom_range(0, R));
            1:       a = $urandom;
            default: a = 32'($urandom_range(0, 63));
         endcase
         do_txn(1'($urandom), a, rand_vec());
      end

      reset_mid_store(rand_vec());
      do_txn(1'b0, 32'h0, rand_vec());

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
      $finish;
   end

endmodule

// File: doc/vector_mem_responder.md
# vector_mem_responder

Memory-side responder for the vector CPU's MEM stage. It accepts one vector load or store request (R lanes of N bits at a 32-bit byte address). It serialises the request into R single-byte accesses on an external synchronous single-port byte RAM, and returns the assembled R-lane read vector with a completion pulse. It sits between the datapath's MEM-stage outputs (`MemWriteM`, `AddressM`, `WriteDataM`) and the data RAM, and supplies the `ReadData` vector. `Ready` low is the stall source for the pipeline.

## Interface
Parameters:
- `R`, 6, number of vector lanes
- `N`, 8, lane width in bits (equals RAM data width)
- `I`, 32, request address width
- `AW`, 10, RAM address width (depth 2^AW bytes)

Ports:
- `clk`  input  1  single clock; all state on rising edge
- `reset`  input  1  asynchronous, active-low; asserting (0) clears all state immediately
- `MemReq`  input  1  request valid; held by requester until accepted
- `MemWrite`  input  1  1 = store, 0 = load; sampled at accept
- `Address`  input  I  base byte address; sampled at accept
- `WriteData`  input  [R-1:0][N-1:0]  store vector; sampled at accept
- `Ready`  output  1  high only in IDLE; accept = `MemReq & Ready`
- `RespValid`  output  1  one-cycle pulse on completion (load or store)
- `Err`  output  1  one-cycle pulse on range violation (only with `VMEM_RANGE_CHECK_EN`; tied 0 otherwise)
- `ReadData`  output  [R-1:0][N-1:0]  last completed load vector; held until next load completes
- `ram_addr`  output  AW  RAM byte address
- `ram_we`  output  1  RAM write enable
- `ram_wdata`  output  N  RAM write data
- `ram_rdata`  input  N  RAM read data; valid the cycle after the address is presented

## Operation
- FSM states: IDLE, WR, RD, RD_LAST, RESP.
- IDLE: `Ready`=1. On accept, capture `MemWrite`, `Address[AW-1:0]`, `WriteData` and clear lane counter k=0. Go to WR (store) or RD (load).
- WR: drive `ram_addr` = base+k, `ram_we`=1, `ram_wdata`=lane k. Increment k. When k=R-1, go to RESP.
- RD: drive `ram_addr` = base+k, `ram_we`=0. From k≥1, capture `ram_rdata` into lane k-1. When k=R-1, go to RD_LAST.
- RD_LAST: capture `ram_rdata` into lane R-1, then go to RESP.
- Lane assembly uses a shadow register. `ReadData` is updated from the shadow only on entry to RESP of a load.
- RESP: `RespValid`=1 for one cycle, then IDLE.
- Address arithmetic: base+k is computed in AW bits and wraps modulo 2^AW. Bits `Address[I-1:AW]` are ignored.
- `MemReq` while busy is ignored. No queuing.
- `MemReq` deasserted in the same cycle `Ready` rises: no action.
- Reset mid-operation: return to IDLE; outputs go to reset values. RAM bytes already written remain written.

## Timing
- Reset values: `Ready`=1, `RespValid`=0, `Err`=0, `ReadData`=0, `ram_addr`=0, `ram_we`=0, `ram_wdata`=0.
- Store: accept at cycle 0; RAM writes on cycles 1..R; `RespValid` at cycle R+1; `Ready` high at R+2.
- Load: accept at cycle 0; addresses on cycles 1..R; data captured on cycles 2..R+1; `ReadData` valid and `RespValid` at cycle R+2; `Ready` high at R+3.
- Back-to-back requests: minimum spacing is R+2 cycles (store) or R+3 cycles (load).

## Configuration
- `VMEM_RANGE_CHECK_EN` defined: at accept, if `Address[I-1:AW]` ≠ 0 or `Address[AW-1:0]`+R-1 ≥ 2^AW, then no RAM access occurs. `Err` pulses at cycle 1, together with `RespValid`. `ReadData` is unchanged. FSM returns to IDLE at cycle 2.
- Not defined: no check; addresses wrap as in Operation; `Err` is constant 0.

## Structure
- Package `vector_mem_pkg`: FSM state enum, default lane count/width constants, lane vector typedef `[R-1:0][N-1:0]`.
- One sub-module: `vmem_lane_pack`, the shadow register plus lane-indexed capture and publish into `ReadData`.
- The FSM and lane counter live in the top module.

## Test plan
- Store then load: `Address`=0x10, `WriteData`={6,5,4,3,2,1}. RAM bytes 0x10..0x15 = 1..6. `RespValid` at cycle 7. Load at the same address: `ReadData`={6,5,4,3,2,1}, `RespValid` at cycle 8.
- Wrap, macro off: store at `Address`=0x3FE. Bytes land at 0x3FE, 0x3FF, 0x000..0x003. Reload returns the same vector.
- Range check, macro on: store at 0x3FE. No `ram_we` ever asserted; `Err` and `RespValid` pulse at cycle 1. Store at 0x400 behaves the same.
- Busy: hold `MemReq`=1 throughout a load. Exactly one access sequence occurs until `Ready` returns; the second request is accepted at cycle 9.
- Reset mid-store: assert `reset`=0 after the third RAM write. Outputs go to reset values immediately. Only bytes 0..2 are written. `Ready`=1 after release.
- `ReadData` hold: after a load returns vector A, a following store leaves `ReadData`=A.
